// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - shared types and constants for the folded Wallace reduction controller
package wallace_pkg;

   localparam int ROW_W    = 48;
   localparam int MAX_ROWS = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of 4:2 compression steps needed to bring n live rows down to two.
   // Counts above MAX_ROWS saturate, and fewer than three rows need no step.
   function automatic logic [3:0] steps(input logic [3:0] n);
      logic [3:0] n_sat;
      n_sat = (n > 4'(MAX_ROWS)) ? 4'(MAX_ROWS) : n;
      if (n_sat <= 4'd2) begin
         steps = 4'd0;
      end else begin
         steps = (n_sat - 4'd1) >> 1;
      end
   endfunction

endpackage

// File: rtl/wallace_fold_seq_compressor.sv
// rtl/wallace_fold_seq_compressor.sv - 4:2 row compressor built from two carry-save full-adder layers
module F_t_file #(
   parameter int W = 48
) (
   input  logic [W-1:0] p_1_i,
   input  logic [W-1:0] p_2_i,
   input  logic [W-1:0] p_3_i,
   input  logic [W-1:0] p_4_i,
   output logic [W-1:0] carry_o,
   output logic [W-1:0] sum_o
);

   logic [W-1:0] s1;
   logic [W-1:0] c1;
   logic [W-1:0] c1_sh;

   // First layer folds p_1..p_3 into a sum and a majority carry.
   assign s1    = p_1_i ^ p_2_i ^ p_3_i;
   assign c1    = (p_1_i & p_2_i) | (p_1_i & p_3_i) | (p_2_i & p_3_i);

   // The intermediate carry moves one column up; its top bit leaves the row (mod 2^W).
   assign c1_sh = c1 << 1;

   // Second layer adds p_4 and the shifted intermediate carry, so that
   // sum_o + (carry_o << 1) == p_1 + p_2 + p_3 + p_4 (mod 2^W).
   assign sum_o   = s1 ^ p_4_i ^ c1_sh;
   assign carry_o = (s1 & p_4_i) | (s1 & c1_sh) | (p_4_i & c1_sh);

endmodule

// File: rtl/wallace_fold_seq.sv
// rtl/wallace_fold_seq.sv - folded Wallace reduction over a row queue with one shared 4:2 compressor
module wallace_fold_seq
   import wallace_pkg::*;
#(
   parameter int W    = ROW_W,
   parameter int ROWS = MAX_ROWS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ROWS*W-1:0]   pp_rows,
   input  logic [3:0]          in_rows,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        carry_out,
   output logic [W-1:0]        sum_out,
   output logic                busy
);

   state_t       state_q, state_d;
   logic [W-1:0] q_q [ROWS];
   logic [W-1:0] q_d [ROWS];
   logic [3:0]   cnt_q, cnt_d;
   logic         out_valid_q;
   logic [W-1:0] carry_q, sum_q;

   logic [3:0]   n_sat;
   logic [3:0]   take;
   logic [3:0]   keep;
   logic [W-1:0] p_row [4];
   logic [W-1:0] cmp_carry;
   logic [W-1:0] cmp_sum;
   logic [W-1:0] carry_sh;
   logic         accept;

   assign n_sat  = (in_rows > 4'(ROWS)) ? 4'(ROWS) : in_rows;
   assign accept = (state_q == IDLE) && in_valid;
   assign take   = (cnt_q >= 4'd4) ? 4'd4 : cnt_q;
   assign keep   = cnt_q - take;

   // Head of the queue feeds the compressor; slots past the live count read as zero.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         p_row[k] = (4'(k) < cnt_q) ? q_q[k] : '0;
      end
   end

   F_t_file #(.W(W)) u_cmp (
      .p_1_i   (p_row[0]),
      .p_2_i   (p_row[1]),
      .p_3_i   (p_row[2]),
      .p_4_i   (p_row[3]),
      .carry_o (cmp_carry),
      .sum_o   (cmp_sum)
   );

   // Carry row is weight-aligned before it re-enters the queue; the bit shifted out is dropped.
   assign carry_sh = cmp_carry << 1;

   // Queue next-state: load on accept, or pop four and append carry then sum while running.
   always_comb begin
      cnt_d = cnt_q;
      for (int r = 0; r < ROWS; r++) begin
         q_d[r] = q_q[r];
      end
      if (accept) begin
         for (int r = 0; r < ROWS; r++) begin
            q_d[r] = (4'(r) < n_sat) ? pp_rows[r*W +: W] : '0;
         end
         cnt_d = (n_sat < 4'd2) ? 4'd2 : n_sat;
      end else if (state_q == RUN) begin
         for (int r = 0; r < ROWS; r++) begin
            if (4'(r) == keep) begin
               q_d[r] = carry_sh;
            end else if (4'(r) == keep + 4'd1) begin
               q_d[r] = cmp_sum;
            end else begin
               q_d[r] = '0;
            end
         end
         for (int r = 0; r < ROWS - 4; r++) begin
            if (4'(r) < keep) begin
               q_d[r] = q_q[r + 4];
            end
         end
         cnt_d = keep + 4'd2;
      end
   end

   // Controller next-state and handshake outputs.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = (n_sat <= 4'd2) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_d == 4'd2) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy = 1'b1;
            if (out_valid_q && out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and row queue registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         for (int r = 0; r < ROWS; r++) begin
            q_q[r] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int r = 0; r < ROWS; r++) begin
            q_q[r] <= q_d[r];
         end
      end
   end

   // Result registers capture the final pair once in DONE and hold it until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         carry_q     <= '0;
         sum_q       <= '0;
      end else if ((state_q == DONE) && !out_valid_q) begin
         out_valid_q <= 1'b1;
         carry_q     <= q_q[0];
         sum_q       <= q_q[1];
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign carry_out = carry_q;
   assign sum_out   = sum_q;

endmodule

// File: tb/tb_wallace_fold_seq.sv
// tb/tb_wallace_fold_seq.sv - randomized self-checking bench for wallace_fold_seq
module tb_wallace_fold_seq;

   localparam int W    = 48;
   localparam int ROWS = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [ROWS*W-1:0] pp_rows;
   logic [3:0]        in_rows;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      carry_out;
   logic [W-1:0]      sum_out;
   logic              busy;

   int n_cmp = 0;
   int n_err = 0;

   wallace_fold_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pp_rows   (pp_rows),
      .in_rows   (in_rows),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .carry_out (carry_out),
      .sum_out   (sum_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int live_rows(input logic [3:0] n);
      return (n > 4'd12) ? 12 : int'(n);
   endfunction

   // Reference latency: walk the row count down two per step until two remain.
   function automatic int model_latency(input logic [3:0] n);
      int c;
      int k;
      c = live_rows(n);
      if (c < 2) c = 2;
      k = 0;
      while (c > 2) begin
         c = c - ((c < 4) ? c : 4) + 2;
         k++;
      end
      return k + 1;
   endfunction

   // Reference result: plain modular sum of the live rows.
   function automatic logic [W-1:0] model_sum(input logic [ROWS*W-1:0] rows, input logic [3:0] n);
      logic [W-1:0] acc;
      acc = '0;
      for (int r = 0; r < live_rows(n); r++) begin
         acc = acc + rows[r*W +: W];
      end
      return acc;
   endfunction

   function automatic logic [W-1:0] rand_row();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [ROWS*W-1:0] rand_rows();
      logic [ROWS*W-1:0] v;
      for (int r = 0; r < ROWS; r++) begin
         v[r*W +: W] = rand_row();
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [ROWS*W-1:0] rows, input logic [3:0] n,
                         input int hold, input bit early_ready);
      int           lat;
      int           eff;
      logic [W-1:0] c_snap;
      logic [W-1:0] s_snap;
      logic [W-1:0] row0;
      logic [W-1:0] row1;
      eff  = live_rows(n);
      row0 = rows[0 +: W];
      row1 = rows[W +: W];
      check({tag, ".in_ready"}, in_ready, 1);
      out_ready = early_ready;
      pp_rows   = rows;
      in_rows   = n;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      pp_rows  = rand_rows();
      in_rows  = 4'($urandom_range(0, 15));
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, ".latency"}, lat, model_latency(n));
      if (!out_valid) begin
         out_ready = 1'b0;
         do_reset(2);
         return;
      end
      check({tag, ".sum"}, W'(carry_out + sum_out), model_sum(rows, n));
      if (eff <= 2) begin
         check({tag, ".carry_pass"}, carry_out, (eff >= 1) ? row0 : '0);
         check({tag, ".sum_pass"}, sum_out, (eff == 2) ? row1 : '0);
      end
      if (early_ready) begin
         tick();
         out_ready = 1'b0;
         check({tag, ".drained"}, {in_ready, out_valid, busy}, 3'b100);
         return;
      end
      c_snap = carry_out;
      s_snap = sum_out;
      if (hold > 0) begin
         in_valid = 1'b1;
         pp_rows  = rand_rows();
         in_rows  = 4'd12;
         repeat (hold) tick();
         in_valid = 1'b0;
         check({tag, ".hold_ctl"}, {in_ready, out_valid, busy}, 3'b011);
         check({tag, ".hold_data"}, {carry_out, sum_out}, {c_snap, s_snap});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".drained"}, {in_ready, out_valid, busy}, 3'b100);
   endtask

   initial begin
      logic [ROWS*W-1:0] rows;
      int                seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      pp_rows   = '0;
      in_rows   = '0;

      do_reset(2);
      check("reset.ctl", {in_ready, out_valid, busy}, 3'b100);
      check("reset.carry", carry_out, 0);
      check("reset.sum", sum_out, 0);

      for (int r = 0; r < ROWS; r++) rows[r*W +: W] = 48'h1;
      run_op("ones12", rows, 4'd12, 0, 1'b0);

      for (int r = 0; r < ROWS; r++) rows[r*W +: W] = 48'hFFFF_FFFF_FFFF;
      run_op("max12", rows, 4'd12, 0, 1'b0);

      rows = '0;
      rows[0 +: W] = 48'hA5;
      rows[W +: W] = 48'h5A;
      run_op("pass2", rows, 4'd2, 0, 1'b0);

      rows = rand_rows();
      rows[0 +: W]   = 48'd3;
      rows[W +: W]   = 48'd5;
      rows[2*W +: W] = 48'd7;
      run_op("three", rows, 4'd3, 0, 1'b0);

      run_op("one", rand_rows(), 4'd1, 2, 1'b0);
      run_op("zero", rand_rows(), 4'd0, 1, 1'b0);
      run_op("sat15", rand_rows(), 4'd15, 0, 1'b0);
      run_op("backpressure", rand_rows(), 4'd9, 10, 1'b0);
      run_op("early_ready", rand_rows(), 4'd7, 0, 1'b1);

      // Abort mid-reduction: reset must win and no result may appear afterwards.
      pp_rows  = rand_rows();
      in_rows  = 4'd12;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      check("abort.busy_before", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.ctl", {in_ready, out_valid, busy}, 3'b100);
      check("abort.carry", carry_out, 0);
      check("abort.sum", sum_out, 0);
      seen = 0;
      repeat (10) begin
         tick();
         if (out_valid) seen++;
      end
      check("abort.no_valid", seen, 0);

      for (int i = 0; i < 40; i++) begin
         run_op($sformatf("rand%0d", i), rand_rows(), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
